// File: rtl/muldiv_pkg.sv
// ============================================================================
// muldiv_pkg : shared opcodes, FSM encodings and helpers for muldiv_unit
// Revision   : 1.0
// ============================================================================
`default_nettype none

package muldiv_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  function automatic logic is_div(input logic [2:0] f3);
    return (f3 == F3_DIV) || (f3 == F3_DIVU) || (f3 == F3_REM) || (f3 == F3_REMU);
  endfunction

  function automatic logic is_rem(input logic [2:0] f3);
    return (f3 == F3_REM) || (f3 == F3_REMU);
  endfunction

  // MUL only keeps the low word, which is sign-agnostic, so it runs unsigned.
  function automatic logic op_a_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic op_b_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic [MD_WIDTH-1:0] neg_word(input logic [MD_WIDTH-1:0] x);
    return ~x + {{(MD_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*MD_WIDTH-1:0] neg_dword(input logic [2*MD_WIDTH-1:0] x);
    return ~x + {{(2*MD_WIDTH-1){1'b0}}, 1'b1};
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// muldiv_unit : iterative RV32M multiply/divide feeding the register bank c-port
// Revision    : 1.0
// ============================================================================
`default_nettype none

module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            funct3,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  input  logic [ADDR_WIDTH-1:0] rd_address,
  output logic                  busy,
  output logic                  done,
  output logic                  write,
  output logic [ADDR_WIDTH-1:0] c_address,
  output logic [WIDTH-1:0]      result
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH);

  state_t                  state_q, state_d;
  logic [CW-1:0]           count_q, count_d;
  logic [2:0]              op_q, op_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [2*WIDTH-1:0]      acc_q, acc_d;
  logic [WIDTH-1:0]        opnd_q, opnd_d;
  logic                    neg_q, neg_d;
  logic                    fast_q, fast_d;
  logic [WIDTH-1:0]        result_q, result_d;

  logic                    sa, sb, fast_hit, div_op;
  logic [WIDTH-1:0]        mag_a, mag_b, neg_a, neg_b, fast_val;
  logic [WIDTH:0]          mul_sum, div_shift, div_diff;
  logic                    q_bit;
  logic [2*WIDTH-1:0]      mul_next, div_next, acc_neg, mul_final;
  logic [WIDTH-1:0]        lo_neg, hi_neg, fin_val;

  // Operand preparation at accept time
  assign div_op = is_div(funct3);
  assign sa     = op_a_signed(funct3) & a[WIDTH-1];
  assign sb     = op_b_signed(funct3) & b[WIDTH-1];
  assign neg_a  = neg_word(a);
  assign neg_b  = neg_word(b);
  assign mag_a  = sa ? neg_a : a;
  assign mag_b  = sb ? neg_b : b;

  always_comb begin
    fast_hit = 1'b0;
    fast_val = '0;
    if (div_op && (b == '0)) begin
      fast_hit = 1'b1;
      fast_val = is_rem(funct3) ? a : '1;
    end else if (((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                 (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1)) begin
      fast_hit = 1'b1;
      fast_val = (funct3 == F3_DIV) ? {1'b1, {(WIDTH-1){1'b0}}} : '0;
    end
  end

  // One iteration: acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign q_bit     = ~div_diff[WIDTH];
  assign div_next  = {(q_bit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                      acc_q[WIDTH-2:0], q_bit};

  assign acc_neg   = neg_dword(acc_q);
  assign lo_neg    = neg_word(acc_q[WIDTH-1:0]);
  assign hi_neg    = neg_word(acc_q[2*WIDTH-1:WIDTH]);
  assign mul_final = neg_q ? acc_neg : acc_q;

  always_comb begin
    case (op_q)
      F3_MUL:                      fin_val = mul_final[WIDTH-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fin_val = mul_final[2*WIDTH-1:WIDTH];
      F3_DIV, F3_DIVU:             fin_val = neg_q ? lo_neg : acc_q[WIDTH-1:0];
      default:                     fin_val = neg_q ? hi_neg : acc_q[2*WIDTH-1:WIDTH];
    endcase
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    op_d     = op_q;
    addr_d   = addr_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    neg_d    = neg_q;
    fast_d   = fast_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          count_d = '0;
          op_d    = funct3;
          addr_d  = rd_address;
          fast_d  = fast_hit;
          neg_d   = is_rem(funct3) ? sa : (sa ^ sb);
          if (fast_hit) begin
            acc_d  = {{WIDTH{1'b0}}, fast_val};
            opnd_d = '0;
          end else if (div_op) begin
            acc_d  = {{WIDTH{1'b0}}, mag_a};
            opnd_d = mag_b;
          end else begin
            acc_d  = {{WIDTH{1'b0}}, mag_b};
            opnd_d = mag_a;
          end
        end
      end
      ST_RUN: begin
        if (fast_q) begin
          state_d  = ST_DONE;
          result_d = acc_q[WIDTH-1:0];
        end else if (count_q == LAST_STEP) begin
          state_d  = ST_DONE;
          result_d = fin_val;
        end else begin
          count_d = count_q + 1'b1;
          acc_d   = is_div(op_q) ? div_next : mul_next;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      op_q     <= '0;
      addr_q   <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      neg_q    <= 1'b0;
      fast_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      neg_q    <= neg_d;
      fast_q   <= fast_d;
      result_q <= result_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign write     = done;
  assign c_address = addr_q;
  assign result    = result_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// tb_muldiv_unit : directed self-checking bench for muldiv_unit
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

  logic        clock;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  rd_address;
  logic        busy;
  logic        done;
  logic        write;
  logic [4:0]  c_address;
  logic [31:0] result;

  int n_vec  = 0;
  int n_miss = 0;
  int write_cnt = 0;

  muldiv_unit #(.WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .funct3     (funct3),
    .a          (a),
    .b          (b),
    .rd_address (rd_address),
    .busy       (busy),
    .done       (done),
    .write      (write),
    .c_address  (c_address),
    .result     (result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) if (write) write_cnt++;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Cycles from the accepting edge until done is seen, bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 60) begin
      step();
      lat++;
    end
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] va, input logic [31:0] vb,
                       input logic [4:0] rd);
    start = 1'b1; funct3 = f; a = va; b = vb; rd_address = rd;
    step();
    start = 1'b0; a = ~va; b = vb ^ 32'h5A5A_0F0F; rd_address = ~rd; funct3 = ~f;
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] va,
                        input logic [31:0] vb, input logic [4:0] rd,
                        input logic [31:0] exp, input int exp_lat);
    int lat;
    issue(f, va, vb, rd);
    wait_done(lat);
    check_vec({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check_vec({tag, " result"}, result, exp);
    check_vec({tag, " c_address"}, {27'd0, c_address}, {27'd0, rd});
    check_vec({tag, " write"}, {31'd0, write}, 32'd1);
    step();
    check_vec({tag, " done drop"}, {30'd0, done, busy}, 32'd0);
  endtask

  initial begin
    int lat;
    int snap;
    reset = 1'b1; start = 1'b0; funct3 = 3'd0; a = '0; b = '0; rd_address = '0;
    repeat (3) step();
    check_vec("reset outs", {29'd0, busy, done, write}, 32'd0);
    check_vec("reset result", result, 32'd0);
    check_vec("reset c_address", {27'd0, c_address}, 32'd0);
    reset = 1'b0;
    step();

    run_op("MUL 7*-3",        3'b000, 32'd7,        32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 33);
    run_op("MULHU -1*-1",     3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFE, 33);
    run_op("MULH -1*-1",      3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'h0000_0000, 33);
    run_op("MULHSU -1*2",     3'b010, 32'hFFFF_FFFF, 32'd2,         5'd6,  32'hFFFF_FFFF, 33);
    run_op("DIV -7/2",        3'b100, 32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFD, 33);
    run_op("REM -7%2",        3'b110, 32'hFFFF_FFF9, 32'd2,         5'd8,  32'hFFFF_FFFF, 33);
    run_op("DIVU 100/7",      3'b101, 32'd100,      32'd7,          5'd9,  32'd14,        33);
    run_op("REMU 100%7",      3'b111, 32'd100,      32'd7,          5'd10, 32'd2,         33);
    run_op("DIVU x/0",        3'b101, 32'h1234,     32'd0,          5'd11, 32'hFFFF_FFFF, 1);
    run_op("REM x/0",         3'b110, 32'h1234,     32'd0,          5'd12, 32'h0000_1234, 1);
    run_op("DIV ovf",         3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1);
    run_op("REM ovf",         3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0000_0000, 1);

    // Second start while busy must be ignored
    issue(3'b101, 32'd100, 32'd7, 5'd15);
    repeat (4) step();
    start = 1'b1; funct3 = 3'b000; a = 32'd50; b = 32'd3; rd_address = 5'd20;
    step();
    start = 1'b0;
    wait_done(lat);
    check_vec("ignore latency", 32'(lat + 5), 32'd33);
    check_vec("ignore result", result, 32'd14);
    check_vec("ignore c_address", {27'd0, c_address}, 32'd15);
    step();

    // Reset mid-RUN aborts without a write pulse
    issue(3'b100, 32'd1000, 32'd3, 5'd21);
    repeat (9) step();
    snap = write_cnt;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_vec("abort busy", {31'd0, busy}, 32'd0);
    check_vec("abort result", result, 32'd0);
    repeat (40) step();
    check_vec("abort no write", 32'(write_cnt - snap), 32'd0);

    // Back-to-back: start held from DONE into the following IDLE cycle
    write_cnt = 0;
    issue(3'b000, 32'd5, 32'd6, 5'd22);
    wait_done(lat);
    check_vec("b2b first", result, 32'd30);
    start = 1'b1; funct3 = 3'b000; a = 32'd3; b = 32'd4; rd_address = 5'd23;
    step();
    check_vec("b2b ignored in done", {31'd0, busy}, 32'd0);
    step();
    start = 1'b0;
    wait_done(lat);
    check_vec("b2b latency", 32'(lat), 32'd33);
    check_vec("b2b second", result, 32'd12);
    check_vec("b2b c_address", {27'd0, c_address}, 32'd23);
    repeat (3) step();
    check_vec("b2b write count", 32'(write_cnt), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide unit that sits directly upstream of register_bank. It consumes the two operands read from the a/b ports and produces a result, destination address and write strobe for the register bank's c-port. It uses a shift-add multiplier and a restoring divider sharing one 32-step datapath, with a start/busy/done handshake toward the control unit.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported; the step counter is sized clog2(WIDTH)+1.
- ADDR_WIDTH, 5, destination register address width; matches the register_bank address ports.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clock.
- start  input  1  request; accepted only when busy=0.
- funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  input  WIDTH  rs1 operand (register_bank a_out).
- b  input  WIDTH  rs2 operand (register_bank b_out).
- rd_address  input  ADDR_WIDTH  destination register.
- busy  output  1  high in RUN and DONE states.
- done  output  1  single-cycle result-valid pulse.
- write  output  1  equal to done; drives register_bank write.
- c_address  output  ADDR_WIDTH  latched rd_address; drives register_bank c_address.
- result  output  WIDTH  drives register_bank c_in; holds its value until the next DONE.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (any state): next state IDLE; busy=0, done=0, write=0, result=0, c_address=0, counter=0.
- Accept, IDLE with start=1 at edge N:
  - latch funct3 and rd_address;
  - compute operand signs (signed: MUL-high ops per RV spec, DIV, REM; MULHSU treats only a as signed);
  - store absolute magnitudes;
  - record the negate flags: product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa.
- Fast path, DIV/DIVU/REM/REMU only, decided at accept:
  - b==0: quotient = all ones, remainder = a.
  - DIV/REM with a=0x80000000 and b=0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
  - The result is loaded directly and DONE is entered at edge N+1.
- Normal path: RUN for exactly 32 cycles, one bit per cycle.
  - Multiply: 64-bit accumulator, add multiplicand if the multiplier LSB is set, shift right.
  - Divide: restoring; shift the remainder left with the next dividend bit, subtract the divisor if it is not negative, and shift a quotient bit in.
  - DONE is entered at edge N+33; sign correction (two's-complement negate) is applied on the RUN->DONE transition.
  - result selection: low 32 bits for MUL; high 32 bits for MULH/MULHSU/MULHU; quotient for DIV/DIVU; remainder for REM/REMU.
- DONE: done=write=1 for exactly one cycle, then IDLE; the next start can be accepted at the edge leaving DONE+1, not in DONE.
- start while busy=1: ignored; no state change and no latching.
- Inputs a/b/funct3/rd_address may change after acceptance without effect.
- reset mid-RUN: aborts; no done or write pulse is produced.
- reset has priority over start at the same edge.

Decomposition:
- Package muldiv_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - localparams for the 8 funct3 codes;
  - helper functions is_div(funct3) and op_a_signed/op_b_signed(funct3).
- There is no sub-module; datapath and FSM share one module. A two's-complement negate function also lives in the package.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (start at edge N) -> done/write high only in cycle after edge N+33, result=0xFFFFFFEB, c_address=rd_address=3.
- MULHU a=b=0xFFFFFFFF -> result 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2.
- DIVU a=0x1234, b=0 -> done after 1 cycle, result 0xFFFFFFFF; REM a=0x1234, b=0 -> 0x1234; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
- Start DIV, pulse start again with other operands at RUN cycle 5 -> ignored, original result delivered; reset at RUN cycle 10 -> busy=0 next cycle, no done pulse, result=0.
- Back-to-back: a new start is asserted in the DONE cycle (ignored) and held through the next cycle (accepted); a second MUL 3*4 -> result 12, with exactly one write pulse per operation (monitor counts 2).
